// File: rtl/fsm_eg_driver.sv
// Command-driven initiator for the two-input/two-output example FSM: drives a/b, checks y0/y1.
// Optional saturating error counter output err_cnt enabled by defining FSM_EG_DRV_ERRCNT_EN.
module fsm_eg_driver #(
   parameter int GAP = 2,
   parameter int CW  = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic       y0,
   input  logic       y1,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] shadow
`ifdef FSM_EG_DRV_ERRCNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   typedef enum logic [2:0] {IDLE, DRIVE, CHECK, CHECK2, GAPW} state_e;

   localparam logic [1:0] CMD_HOME  = 2'b00;
   localparam logic [1:0] CMD_ENTER = 2'b01;
   localparam logic [1:0] CMD_LEAVE = 2'b10;
   localparam logic [1:0] CMD_PULSE = 2'b11;

   localparam logic [1:0] SH_S0 = 2'b00;
   localparam logic [1:0] SH_S1 = 2'b01;
   localparam logic [1:0] SH_S2 = 2'b10;

   state_e          state_q, state_d;
   logic [1:0]      cmd_q, cmd_d;
   logic [1:0]      shadow_q, shadow_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mis_q, mis_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            y1Ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cmd_q    <= CMD_HOME;
         shadow_q <= SH_S0;
         cnt_q    <= '0;
         mis_q    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         mis_q    <= mis_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // A mismatch seen before the final check is held in mis_q so err always lands with done.
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      mis_d    = mis_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      y1Ok     = (y1 == (shadow_q != SH_S2));
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            mis_d = 1'b0;
            if (start) begin
               case (cmd)
                  CMD_HOME: begin
                     if (shadow_q == SH_S0) begin
                        done_d  = 1'b1;
                        state_d = GAPW;
                     end else begin
                        cmd_d   = CMD_LEAVE;
                        state_d = DRIVE;
                     end
                  end
                  CMD_LEAVE: begin
                     if (shadow_q != SH_S1) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = GAPW;
                     end else begin
                        cmd_d   = CMD_LEAVE;
                        state_d = DRIVE;
                     end
                  end
                  default: begin
                     if (shadow_q != SH_S0) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = GAPW;
                     end else begin
                        cmd_d   = cmd;
                        state_d = DRIVE;
                     end
                  end
               endcase
            end
         end
         DRIVE: begin
            if (y0 != (cmd_q == CMD_PULSE)) mis_d = 1'b1;
            case (cmd_q)
               CMD_ENTER: shadow_d = SH_S1;
               CMD_PULSE: shadow_d = SH_S2;
               default:   shadow_d = SH_S0;
            endcase
            state_d = CHECK;
         end
         CHECK: begin
            if (cmd_q == CMD_PULSE) begin
               mis_d   = mis_q | ~y1Ok;
               state_d = CHECK2;
            end else begin
               done_d  = 1'b1;
               err_d   = mis_q | ~y1Ok;
               state_d = GAPW;
            end
         end
         CHECK2: begin
            done_d   = 1'b1;
            err_d    = mis_q | ~y1;
            shadow_d = SH_S0;
            state_d  = GAPW;
         end
         GAPW: begin
            if (cnt_q >= CW'(GAP)) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign a      = (state_q == DRIVE);
   assign b      = (state_q == DRIVE) && (cmd_q == CMD_PULSE);
   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign err    = err_q;
   assign shadow = shadow_q;

`ifdef FSM_EG_DRV_ERRCNT_EN
   logic [7:0] errCnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         errCnt_q <= '0;
      end else if (err_d && errCnt_q != 8'hFF) begin
         errCnt_q <= errCnt_q + 8'd1;
      end
   end

   assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_fsm_eg_driver.sv
// Bench for fsm_eg_driver: behavioural target FSM, directed table, hand sequences, random commands.
// Checks err_cnt as well when FSM_EG_DRV_ERRCNT_EN is defined.
module tb_fsm_eg_driver;

   localparam int TB_GAP = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic       y0, y1, a, b, busy, done, err;
   logic [1:0] shadow;
`ifdef FSM_EG_DRV_ERRCNT_EN
   logic [7:0] err_cnt;
`endif

   int total = 0;
   int bad = 0;
   int expErrCnt = 0;

   // Target FSM: 0=s0, 1=s1, 2=s2; faultOn forces y1 high to fake a broken target.
   int  tstate;
   bit  faultOn = 1'b0;

   always #5 clk = ~clk;

   fsm_eg_driver #(.GAP(TB_GAP), .CW(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd),
      .y0(y0), .y1(y1), .a(a), .b(b), .busy(busy), .done(done),
      .err(err), .shadow(shadow)
`ifdef FSM_EG_DRV_ERRCNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tstate <= 0;
      else begin
         case (tstate)
            0: if (a && b) tstate <= 2; else if (a) tstate <= 1;
            1: if (a) tstate <= 0;
            default: tstate <= 0;
         endcase
      end
   end

   assign y0 = (tstate == 0) && a && b;
   assign y1 = faultOn || (tstate != 2);

   typedef struct {
      logic [1:0] cmd;
      bit         fault;
      bit         expErr;
      logic [1:0] expShadow;
      int         expLat;
      int         expA;
      int         expB;
   } vec_t;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Issues one command from idle and measures latency, pulses and busy length.
   task automatic applyStimulus(input logic [1:0] c, input bit fault,
                                output int lat, output int errAtDone, output int doneCnt,
                                output int aCnt, output int bCnt, output int busyLen);
      int k;
      lat = -1; errAtDone = 0; doneCnt = 0; aCnt = 0; bCnt = 0; busyLen = -1;
      @(negedge clk);
      faultOn = fault;
      start = 1'b1;
      cmd = c;
      for (k = 1; k < 60; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            doneCnt++;
            lat = k;
            errAtDone = int'(err);
         end
         if (a) aCnt++;
         if (b) bCnt++;
         if (!busy) begin
            busyLen = k - 1;
            break;
         end
      end
      faultOn = 1'b0;
      if (busyLen < 0) begin
         total++;
         bad++;
         $display("[TB] FAIL busyBound: busy still high after %0d cycles, expected release", k);
      end
   endtask

   task automatic checkCommand(input string tag, input vec_t v, input int lat, input int errAtDone,
                               input int doneCnt, input int aCnt, input int bCnt, input int busyLen);
      checkOutput({tag, ".lat"}, lat, v.expLat);
      checkOutput({tag, ".err"}, errAtDone, int'(v.expErr));
      checkOutput({tag, ".doneCnt"}, doneCnt, 1);
      checkOutput({tag, ".aCnt"}, aCnt, v.expA);
      checkOutput({tag, ".bCnt"}, bCnt, v.expB);
      checkOutput({tag, ".busyLen"}, busyLen, v.expLat + TB_GAP);
      checkOutput({tag, ".shadow"}, int'(shadow), int'(v.expShadow));
      if (v.expErr) expErrCnt++;
   endtask

   initial begin
      vec_t vecs[$];
      int lat, errAtDone, doneCnt, aCnt, bCnt, busyLen;
      int sh, doneSeen;

      // Directed table, starting from reset (target in s0).
      vecs.push_back('{2'b01, 0, 0, 2'b01, 3, 1, 0});
      vecs.push_back('{2'b10, 0, 0, 2'b00, 3, 1, 0});
      vecs.push_back('{2'b11, 0, 0, 2'b00, 4, 1, 1});
      vecs.push_back('{2'b10, 0, 1, 2'b00, 1, 0, 0});
      vecs.push_back('{2'b00, 0, 0, 2'b00, 1, 0, 0});
      vecs.push_back('{2'b01, 0, 0, 2'b01, 3, 1, 0});
      vecs.push_back('{2'b00, 0, 0, 2'b00, 3, 1, 0});
      vecs.push_back('{2'b11, 1, 1, 2'b00, 4, 1, 1});
      vecs.push_back('{2'b11, 0, 0, 2'b00, 4, 1, 1});
      vecs.push_back('{2'b01, 0, 0, 2'b01, 3, 1, 0});
      vecs.push_back('{2'b11, 0, 1, 2'b01, 1, 0, 0});
      vecs.push_back('{2'b01, 0, 1, 2'b01, 1, 0, 0});
      vecs.push_back('{2'b10, 0, 0, 2'b00, 3, 1, 0});

      #12;
      checkOutput("reset.a", int'(a), 0);
      checkOutput("reset.b", int'(b), 0);
      checkOutput("reset.busy", int'(busy), 0);
      checkOutput("reset.done", int'(done), 0);
      checkOutput("reset.err", int'(err), 0);
      checkOutput("reset.shadow", int'(shadow), 0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].cmd, vecs[i].fault, lat, errAtDone, doneCnt, aCnt, bCnt, busyLen);
         checkCommand($sformatf("vec%0d", i), vecs[i], lat, errAtDone, doneCnt, aCnt, bCnt, busyLen);
      end

      // Start held high while busy must be ignored: only one command completes.
      @(negedge clk);
      start = 1'b1;
      cmd = 2'b01;
      doneSeen = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         cmd = 2'b10;
         if (k == 3) start = 1'b0;
         if (done) doneSeen++;
         if (!busy && k > 3) break;
      end
      start = 1'b0;
      checkOutput("ignore.doneCnt", doneSeen, 1);
      checkOutput("ignore.shadow", int'(shadow), 1);
      applyStimulus(2'b10, 0, lat, errAtDone, doneCnt, aCnt, bCnt, busyLen);
      checkCommand("ignore.leave", '{2'b10, 0, 0, 2'b00, 3, 1, 0}, lat, errAtDone, doneCnt, aCnt, bCnt, busyLen);

      // Reset asserted during DRIVE of ENTER_S1.
      @(negedge clk);
      start = 1'b1;
      cmd = 2'b01;
      @(negedge clk);
      start = 1'b0;
      checkOutput("midrst.aBefore", int'(a), 1);
      reset_n = 1'b0;
      #1;
      checkOutput("midrst.a", int'(a), 0);
      checkOutput("midrst.busy", int'(busy), 0);
      checkOutput("midrst.shadow", int'(shadow), 0);
      doneSeen = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      checkOutput("midrst.noDone", doneSeen, 0);
      reset_n = 1'b1;
      expErrCnt = 0;
      start = 1'b1;
      cmd = 2'b01;
      @(negedge clk);
      start = 1'b0;
      checkOutput("midrst.accept", int'(a), 1);
      for (int k = 0; k < 20 && busy; k++) @(negedge clk);
      checkOutput("midrst.shadowAfter", int'(shadow), 1);

      // Random commands against a rule-level model of the driver.
      sh = 1;
      for (int i = 0; i < 40; i++) begin
         vec_t v;
         bit legal, noop;
         v.cmd   = 2'($urandom_range(0, 3));
         v.fault = (v.cmd == 2'b11) && ($urandom_range(0, 3) == 0);
         legal = (v.cmd == 2'b00) || (v.cmd == 2'b01 && sh == 0) ||
                 (v.cmd == 2'b10 && sh == 1) || (v.cmd == 2'b11 && sh == 0);
         noop  = (v.cmd == 2'b00) && (sh == 0);
         v.expErr = !legal || (v.fault && legal);
         if (legal && !noop) begin
            v.expLat = (v.cmd == 2'b11) ? 4 : 3;
            v.expA   = 1;
            v.expB   = (v.cmd == 2'b11) ? 1 : 0;
            sh       = (v.cmd == 2'b01) ? 1 : 0;
         end else begin
            v.expLat = 1;
            v.expA   = 0;
            v.expB   = 0;
         end
         v.expShadow = 2'(sh);
         applyStimulus(v.cmd, v.fault, lat, errAtDone, doneCnt, aCnt, bCnt, busyLen);
         checkCommand($sformatf("rnd%0d", i), v, lat, errAtDone, doneCnt, aCnt, bCnt, busyLen);
      end

`ifdef FSM_EG_DRV_ERRCNT_EN
      checkOutput("errCnt", int'(err_cnt), expErrCnt);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
